// File: rtl/trdb_stream_arbiter.sv
// Merges the trace packet stream and the sw dump stream into one registered output word stream.
// Packets win by default. A starvation counter forces pending sw words through, and a flush FSM confirms a full drain.
module trdb_stream_arbiter #(
  parameter int XLEN        = 32,
  parameter int MAX_SW_WAIT = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] packet_word_i,
  input  logic            packet_valid_i,
  output logic            packet_grant_o,
  input  logic [XLEN-1:0] sw_word_i,
  input  logic            sw_valid_i,
  output logic            sw_grant_o,
  output logic [XLEN-1:0] word_o,
  output logic            word_is_sw_o,
  output logic            word_valid_o,
  input  logic            word_grant_i,
  input  logic            flush_stream_i,
  output logic            flush_confirm_o,
  output logic            busy_o
);

  localparam int CW = $clog2(MAX_SW_WAIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_SW_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CONFIRM, ST_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_word;
  logic            r_is_sw;
  logic            r_valid;
  logic [CW-1:0]   r_starve;

  logic w_load;
  logic w_arb_en;
  logic w_force_sw;
  logic w_pkt_grant;
  logic w_sw_grant;
  logic w_drained;

  // Grants are gated by reset so nothing is consumed while the block is held in reset.
  always_comb begin
    w_load      = ~r_valid | word_grant_i;
    w_arb_en    = rst_ni & w_load & (r_state != ST_CONFIRM);
    w_force_sw  = (r_starve == STARVE_MAX) & sw_valid_i;
    w_sw_grant  = w_arb_en & sw_valid_i & (w_force_sw | ~packet_valid_i);
    w_pkt_grant = w_arb_en & packet_valid_i & ~w_force_sw;
    w_drained   = ~packet_valid_i & ~sw_valid_i & w_load;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word  <= '0;
      r_is_sw <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      if (w_pkt_grant) begin
        r_word  <= packet_word_i;
        r_is_sw <= 1'b0;
        r_valid <= 1'b1;
      end else if (w_sw_grant) begin
        r_word  <= sw_word_i;
        r_is_sw <= 1'b1;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // Counts every cycle a pending sw word is passed over, sink stalls included.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= '0;
    end else if (sw_valid_i && !w_sw_grant) begin
      if (r_starve != STARVE_MAX) r_starve <= r_starve + CW'(1);
    end else begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // HOLD keeps a still-set flush bit from retriggering right after the confirm pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (flush_stream_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!flush_stream_i) w_state_nxt = ST_IDLE;
        else if (w_drained)  w_state_nxt = ST_CONFIRM;
      end
      ST_CONFIRM: w_state_nxt = ST_HOLD;
      ST_HOLD:    if (!flush_stream_i) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  assign packet_grant_o  = w_pkt_grant;
  assign sw_grant_o      = w_sw_grant;
  assign word_o          = r_word;
  assign word_is_sw_o    = r_is_sw;
  assign word_valid_o    = r_valid;
  assign flush_confirm_o = (r_state == ST_CONFIRM);
  assign busy_o          = r_valid | (r_state != ST_IDLE);

endmodule
